// File: rtl/ftdi_fifo_phy.sv
// FT245-style parallel-FIFO PHY: buffered send/receive paths, strobe timing,
// RX/TX arbitration, SIWU flush generation and activity LEDs.
module ftdi_fifo_phy #(
  parameter int unsigned CAddrLen   = 8,
  parameter int unsigned CStrobeLen = 1,
  parameter int unsigned CArbMode   = 0,
  parameter int unsigned CFlushIdle = 4,
  parameter int unsigned CLedLen    = 12
) (
  input  logic       AClkH,
  input  logic       AResetH,
  input  logic       AClkHEn,
  input  logic [7:0] ADbgDataI,
  output logic [7:0] ADbgDataO,
  output logic       ADbgDataOE,
  input  logic       ADbgRF,
  input  logic       ADbgTE,
  output logic       ADbgRd,
  output logic       ADbgWr,
  output logic       ADbgSiwu,
  output logic [1:0] ADbgLed,
  input  logic       ASync1M,
  input  logic [7:0] ASendData,
  input  logic       ASendNow,
  output logic       ASendHasSpace,
  output logic [7:0] ARecvData,
  input  logic       ARecvRdEn,
  output logic       ARecvHasData,
  input  logic       AFlushReq,
  output logic       ASendOvf,
  input  logic       AClrErr
);

  localparam int unsigned CDepth = 1 << CAddrLen;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_STB,
    S_RD_CAP,
    S_WR_SETUP,
    S_WR_STB,
    S_GAP
  } state_t;

  state_t r_state, w_next;

  logic       r_frf, r_fte;
  logic [3:0] r_stb_cnt;
  logic       w_stb_last;
  logic [7:0] r_rd_byte;
  logic       r_last_rd;

  // Send FIFO
  logic [7:0]        r_smem [CDepth];
  logic [CAddrLen-1:0] r_swp, r_srp;
  logic [CAddrLen:0]   r_scnt;
  logic w_sfull, w_sempty, w_spush, w_spop;

  // Receive FIFO
  logic [7:0]        r_rmem [CDepth];
  logic [CAddrLen-1:0] r_rwp, r_rrp;
  logic [CAddrLen:0]   r_rcnt;
  logic w_rfull, w_rempty, w_rpush, w_rpop;

  logic       w_rd_ok, w_wr_ok, w_busy;
  logic       r_seen_busy;
  logic [3:0] r_idle_cnt;
  logic       r_siwu;
  logic       r_ovf;
  logic [CLedLen-1:0] r_led_rx, r_led_tx;

  assign w_sfull  = (r_scnt == (CAddrLen+1)'(CDepth));
  assign w_sempty = (r_scnt == '0);
  assign w_rfull  = (r_rcnt == (CAddrLen+1)'(CDepth));
  assign w_rempty = (r_rcnt == '0);

  assign w_stb_last = (r_stb_cnt == 4'(CStrobeLen - 1));
  assign w_spush    = ASendNow && !w_sfull;
  assign w_spop     = (r_state == S_WR_STB) && w_stb_last;
  assign w_rpush    = (r_state == S_RD_CAP) && !w_rfull;
  assign w_rpop     = ARecvRdEn && !w_rempty;

  assign w_rd_ok = r_frf && !w_rfull;
  assign w_wr_ok = r_fte && !w_sempty;
  assign w_busy  = !w_sempty || (r_state == S_WR_SETUP) || (r_state == S_WR_STB);

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      r_frf <= 1'b0;
      r_fte <= 1'b0;
    end else if (AClkHEn) begin
      r_frf <= ADbgRF;
      r_fte <= ADbgTE;
    end
  end

  // FSM: state register
  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) r_state <= S_IDLE;
    else if (AClkHEn) r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rd_ok && w_wr_ok)
          w_next = (CArbMode == 0 || !r_last_rd) ? S_RD_STB : S_WR_SETUP;
        else if (w_rd_ok)
          w_next = S_RD_STB;
        else if (w_wr_ok)
          w_next = S_WR_SETUP;
      end
      S_RD_STB:   if (w_stb_last) w_next = S_RD_CAP;
      S_RD_CAP:   w_next = S_GAP;
      S_WR_SETUP: w_next = S_WR_STB;
      S_WR_STB:   if (w_stb_last) w_next = S_GAP;
      S_GAP:      w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // FSM: outputs (decoded from the async-reset state, so they drop with reset)
  always_comb begin
    ADbgRd     = (r_state == S_RD_STB);
    ADbgWr     = (r_state == S_WR_STB);
    ADbgDataOE = (r_state == S_WR_SETUP) || (r_state == S_WR_STB);
    ADbgDataO  = ADbgDataOE ? r_smem[r_srp] : '0;
  end

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      r_stb_cnt <= '0;
      r_rd_byte <= '0;
      r_last_rd <= 1'b0;
    end else if (AClkHEn) begin
      if ((r_state == S_RD_STB || r_state == S_WR_STB) && !w_stb_last)
        r_stb_cnt <= r_stb_cnt + 4'd1;
      else
        r_stb_cnt <= '0;
      if (r_state == S_RD_STB && w_stb_last)
        r_rd_byte <= ADbgDataI;
      if (r_state == S_IDLE && w_next == S_RD_STB)
        r_last_rd <= 1'b1;
      else if (r_state == S_IDLE && w_next == S_WR_SETUP)
        r_last_rd <= 1'b0;
    end
  end

  always_ff @(posedge AClkH) begin
    if (AClkHEn && w_spush) r_smem[r_swp] <= ASendData;
    if (AClkHEn && w_rpush) r_rmem[r_rwp] <= r_rd_byte;
  end

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      r_swp  <= '0;
      r_srp  <= '0;
      r_scnt <= '0;
      r_rwp  <= '0;
      r_rrp  <= '0;
      r_rcnt <= '0;
    end else if (AClkHEn) begin
      if (w_spush) r_swp <= r_swp + 1'b1;
      if (w_spop)  r_srp <= r_srp + 1'b1;
      if (w_spush && !w_spop)      r_scnt <= r_scnt + (CAddrLen+1)'(1);
      else if (!w_spush && w_spop) r_scnt <= r_scnt - (CAddrLen+1)'(1);
      if (w_rpush) r_rwp <= r_rwp + 1'b1;
      if (w_rpop)  r_rrp <= r_rrp + 1'b1;
      if (w_rpush && !w_rpop)      r_rcnt <= r_rcnt + (CAddrLen+1)'(1);
      else if (!w_rpush && w_rpop) r_rcnt <= r_rcnt - (CAddrLen+1)'(1);
    end
  end

  // A flush request while busy needs no storage: busy arms the idle rule anyway.
  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      r_seen_busy <= 1'b0;
      r_idle_cnt  <= '0;
      r_siwu      <= 1'b0;
    end else if (AClkHEn) begin
      r_siwu <= 1'b0;
      if (w_busy) begin
        r_seen_busy <= 1'b1;
        r_idle_cnt  <= '0;
      end else if (AFlushReq) begin
        r_siwu      <= 1'b1;
        r_seen_busy <= 1'b0;
        r_idle_cnt  <= '0;
      end else if (r_seen_busy) begin
        if (r_idle_cnt == 4'(CFlushIdle - 1)) begin
          r_siwu      <= 1'b1;
          r_seen_busy <= 1'b0;
          r_idle_cnt  <= '0;
        end else begin
          r_idle_cnt <= r_idle_cnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      r_ovf <= 1'b0;
    end else if (AClkHEn) begin
      if (ASendNow && w_sfull) r_ovf <= 1'b1;
      else if (AClrErr)        r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      r_led_rx <= '0;
      r_led_tx <= '0;
    end else if (AClkHEn) begin
      if (r_state == S_IDLE && w_next == S_RD_STB) r_led_rx <= '1;
      else if (ASync1M && r_led_rx != '0)           r_led_rx <= r_led_rx - 1'b1;
      if (r_state == S_IDLE && w_next == S_WR_SETUP) r_led_tx <= '1;
      else if (ASync1M && r_led_tx != '0)             r_led_tx <= r_led_tx - 1'b1;
    end
  end

  assign ADbgSiwu      = r_siwu;
  assign ADbgLed       = {(r_led_tx != '0), (r_led_rx != '0)};
  assign ASendOvf      = r_ovf;
  assign ASendHasSpace = !w_sfull;
  assign ARecvHasData  = !w_rempty;
  assign ARecvData     = w_rempty ? '0 : r_rmem[r_rrp];

endmodule

// File: tb/tb_ftdi_fifo_phy.sv
// Scoreboard bench for ftdi_fifo_phy: pad model at the FTDI side, queues of
// expected bytes for both directions, plus a second instance for fixed priority.
module tb_ftdi_fifo_phy;
  localparam int unsigned AW = 3;
  localparam int unsigned SL = 2;
  localparam int unsigned FI = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [7:0] dati = 8'h00, dato;
  logic       oe, rd, wr, siwu;
  logic       rf = 1'b0, te = 1'b0;
  logic [1:0] led;
  logic       sync1m = 1'b0;
  logic [7:0] sdata = 8'h00;
  logic       snow = 1'b0, sspace;
  logic [7:0] rdata;
  logic       rden = 1'b0, rhas, freq = 1'b0, ovf, clr = 1'b0;

  logic [7:0] z_dato, z_rdata;
  logic       z_oe, z_rd, z_wr, z_siwu, z_sspace, z_rhas, z_ovf;
  logic [1:0] z_led;
  logic       z_rf = 1'b0, z_te = 1'b0, z_snow = 1'b0;
  logic [7:0] z_sdata = 8'h00;

  always #5 clk = ~clk;

  ftdi_fifo_phy #(.CAddrLen(AW), .CStrobeLen(SL), .CArbMode(1), .CFlushIdle(FI), .CLedLen(4)) u_dut (
    .AClkH(clk), .AResetH(rst), .AClkHEn(en),
    .ADbgDataI(dati), .ADbgDataO(dato), .ADbgDataOE(oe),
    .ADbgRF(rf), .ADbgTE(te), .ADbgRd(rd), .ADbgWr(wr), .ADbgSiwu(siwu), .ADbgLed(led),
    .ASync1M(sync1m), .ASendData(sdata), .ASendNow(snow), .ASendHasSpace(sspace),
    .ARecvData(rdata), .ARecvRdEn(rden), .ARecvHasData(rhas),
    .AFlushReq(freq), .ASendOvf(ovf), .AClrErr(clr));

  ftdi_fifo_phy #(.CAddrLen(AW), .CStrobeLen(SL), .CArbMode(0), .CFlushIdle(FI), .CLedLen(4)) u_dut0 (
    .AClkH(clk), .AResetH(rst), .AClkHEn(en),
    .ADbgDataI(8'h33), .ADbgDataO(z_dato), .ADbgDataOE(z_oe),
    .ADbgRF(z_rf), .ADbgTE(z_te), .ADbgRd(z_rd), .ADbgWr(z_wr), .ADbgSiwu(z_siwu), .ADbgLed(z_led),
    .ASync1M(1'b0), .ASendData(z_sdata), .ASendNow(z_snow), .ASendHasSpace(z_sspace),
    .ARecvData(z_rdata), .ARecvRdEn(1'b0), .ARecvHasData(z_rhas),
    .AFlushReq(1'b0), .ASendOvf(z_ovf), .AClrErr(1'b0));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] pad_q[$];
  logic [7:0] rxq[$];
  logic [7:0] wq[$];
  bit         ev_rd[$];
  bit rf_en = 1'b0, te_en = 1'b0, skip_w = 1'b0;
  bit prev_rd = 1'b0, prev_wr = 1'b0;
  int cyc = 0, rd_rise = 0, wr_rise = 0, rd_w = 0, wr_w = 0;
  int siwu_n = 0, siwu_cyc = 0, wr_fall_cyc = 0;

  // Pad model and send-side scoreboard, sampled 1 time unit after each edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (wr && !prev_wr) begin
      wr_rise++;
      wr_w = 1;
      ev_rd.push_back(1'b0);
      check("wr_oe", 32'(oe), 1);
      check("wr_pending", 32'(wq.size() != 0), 1);
      if (wq.size() != 0) check("wr_data", 32'(dato), 32'(wq.pop_front()));
    end else if (wr) begin
      wr_w++;
    end else if (prev_wr) begin
      if (!skip_w) check("wr_width", wr_w, SL);
      wr_fall_cyc = cyc;
    end
    if (rd && !prev_rd) begin
      rd_rise++;
      rd_w = 1;
      ev_rd.push_back(1'b1);
    end else if (rd) begin
      rd_w++;
    end else if (prev_rd) begin
      check("rd_width", rd_w, SL);
      if (pad_q.size() != 0) void'(pad_q.pop_front());
    end
    if (rd) check("rd_oe", 32'(oe), 0);
    if (siwu) begin
      siwu_n++;
      siwu_cyc = cyc;
    end
    prev_rd = rd;
    prev_wr = wr;
    dati = (pad_q.size() != 0) ? pad_q[0] : 8'h00;
    rf   = rf_en && (pad_q.size() != 0);
    te   = te_en;
  end

  int z_rd_n = 0, z_wr_n = 0;
  logic [7:0] z_wdata = 8'h00;
  bit z_prev_rd = 1'b0, z_prev_wr = 1'b0;
  always @(posedge clk) begin
    #1;
    if (z_rd && !z_prev_rd) z_rd_n++;
    if (z_wr && !z_prev_wr) begin
      z_wr_n++;
      z_wdata = z_dato;
    end
    z_prev_rd = z_rd;
    z_prev_wr = z_wr;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_send(input logic [7:0] b, input bit keep);
    @(negedge clk);
    sdata = b;
    snow  = 1'b1;
    if (keep) wq.push_back(b);
    @(negedge clk);
    snow = 1'b0;
  endtask

  task automatic recv_pop();
    for (int i = 0; i < 200 && !rhas; i++) @(negedge clk);
    check("rx_avail", 32'(rhas), 1);
    if (rhas) begin
      check("rx_expected", 32'(rxq.size() != 0), 1);
      if (rxq.size() != 0) check("rx_data", 32'(rdata), 32'(rxq.pop_front()));
      rden = 1'b1;
      @(negedge clk);
      rden = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    bit exp_first_rd;

    // Reset values
    #2;
    check("rst_dato", 32'(dato), 0);
    check("rst_oe", 32'(oe), 0);
    check("rst_rd", 32'(rd), 0);
    check("rst_wr", 32'(wr), 0);
    check("rst_siwu", 32'(siwu), 0);
    check("rst_led", 32'(led), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_rhas", 32'(rhas), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_sspace", 32'(sspace), 1);
    tick(3);
    rst = 1'b0;

    // Mode-0 instance: preload a byte before its pads become ready
    @(negedge clk);
    z_sdata = 8'h77;
    z_snow  = 1'b1;
    @(negedge clk);
    z_snow = 1'b0;

    // Writes: 0x12, 0x34 then a single SIWU
    te_en = 1'b1;
    tick(3);
    @(negedge clk);
    sdata = 8'h12;
    snow  = 1'b1;
    wq.push_back(8'h12);
    @(negedge clk);
    check("setup_lat_oe0", 32'(oe), 0);
    sdata = 8'h34;
    wq.push_back(8'h34);
    @(negedge clk);
    snow = 1'b0;
    check("setup_oe", 32'(oe), 1);
    check("setup_wr", 32'(wr), 0);
    for (int i = 0; i < 100 && siwu_n == 0; i++) @(negedge clk);
    check("siwu_count", siwu_n, 1);
    check("siwu_delay", siwu_cyc - wr_fall_cyc, FI);
    check("wq_drained", wq.size(), 0);
    tick(10);
    check("siwu_single", siwu_n, 1);
    check("led_tx", 32'(led), 2'b10);

    // Flush request while idle
    @(negedge clk);
    freq = 1'b1;
    @(negedge clk);
    freq = 1'b0;
    check("flushreq_pulse", 32'(siwu), 1);
    @(negedge clk);
    check("flushreq_end", 32'(siwu), 0);

    // Reads 0xA5, 0x5A
    te_en = 1'b0;
    tick(2);
    @(negedge clk);
    pad_q.push_back(8'hA5); rxq.push_back(8'hA5);
    pad_q.push_back(8'h5A); rxq.push_back(8'h5A);
    rf_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rd_lat0", 32'(rd), 0);
    @(negedge clk);
    check("rd_lat", 32'(rd), 1);
    recv_pop();
    recv_pop();
    tick(4);
    check("rx_empty", 32'(rhas), 0);
    check("led_rx", 32'(led[0]), 1);
    rf_en = 1'b0;

    // Round-robin with both directions ready
    tick(4);
    for (int k = 0; k < 4; k++) push_send(8'h81 + 8'(k), 1'b1);
    for (int k = 0; k < 4; k++) begin
      pad_q.push_back(8'h01 + 8'(k));
      rxq.push_back(8'h01 + 8'(k));
    end
    base = ev_rd.size();
    exp_first_rd = !ev_rd[ev_rd.size() - 1];
    @(negedge clk);
    rf_en = 1'b1;
    te_en = 1'b1;
    for (int i = 0; i < 400 && ev_rd.size() < base + 8; i++) @(negedge clk);
    check("arb_events", ev_rd.size() - base, 8);
    for (int k = 0; k < 8 && base + k < ev_rd.size(); k++)
      check("arb_seq", 32'(ev_rd[base + k]), 32'(exp_first_rd ^ 1'(k % 2)));
    for (int k = 0; k < 4; k++) recv_pop();
    rf_en = 1'b0;

    // Fixed receive priority on the mode-0 instance
    @(negedge clk);
    z_rf = 1'b1;
    z_te = 1'b1;
    tick(24);
    check("arb0_reads", 32'(z_rd_n >= 3), 1);
    check("arb0_no_write", z_wr_n, 0);
    z_rf = 1'b0;
    tick(15);
    check("arb0_write", z_wr_n, 1);
    check("arb0_wdata", 32'(z_wdata), 8'h77);

    // Send FIFO full and overflow
    te_en = 1'b0;
    tick(20);
    for (int k = 0; k < (1 << AW); k++) push_send(8'h40 + 8'(k), 1'b1);
    check("full_space", 32'(sspace), 0);
    check("pre_ovf", 32'(ovf), 0);
    push_send(8'hFF, 1'b0);
    check("ovf_set", 32'(ovf), 1);
    @(negedge clk);
    clr = 1'b1;
    snow = 1'b1;
    sdata = 8'hFE;
    @(negedge clk);
    clr = 1'b0;
    snow = 1'b0;
    check("ovf_wins", 32'(ovf), 1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("ovf_clr", 32'(ovf), 0);
    te_en = 1'b1;
    for (int i = 0; i < 300 && wq.size() != 0; i++) @(negedge clk);
    tick(6);
    check("full_drained", wq.size(), 0);
    check("full_space_back", 32'(sspace), 1);

    // Receive FIFO full: reads stop, one pop permits exactly one read
    te_en = 1'b0;
    tick(12);
    base = rd_rise;
    for (int k = 0; k < 10; k++) begin
      pad_q.push_back(8'hC0 + 8'(k));
      rxq.push_back(8'hC0 + 8'(k));
    end
    rf_en = 1'b1;
    tick(80);
    check("rxfull_reads", rd_rise - base, 1 << AW);
    check("rxfull_rd_low", 32'(rd), 0);
    check("rxfull_pad_left", pad_q.size(), 2);
    recv_pop();
    tick(30);
    check("rxfull_one_more", rd_rise - base, (1 << AW) + 1);
    check("rxfull_pad_left1", pad_q.size(), 1);
    for (int k = 0; k < 9; k++) recv_pop();
    check("rxq_empty", rxq.size(), 0);
    rf_en = 1'b0;

    // LED stretch expiry
    tick(4);
    sync1m = 1'b1;
    tick(20);
    sync1m = 1'b0;
    check("led_off", 32'(led), 0);

    // Reset during WrStb
    skip_w = 1'b1;
    tick(4);
    push_send(8'h90, 1'b1);
    push_send(8'h91, 1'b0);
    push_send(8'h92, 1'b0);
    te_en = 1'b1;
    for (int i = 0; i < 50 && !wr; i++) @(negedge clk);
    check("rst_wr_seen", 32'(wr), 1);
    rst = 1'b1;
    #1;
    check("rst_async_wr", 32'(wr), 0);
    check("rst_async_oe", 32'(oe), 0);
    @(negedge clk);
    rst = 1'b0;
    base = wr_rise;
    tick(30);
    check("rst_no_write", wr_rise - base, 0);
    check("rst_sspace", 32'(sspace), 1);
    check("rst_wq", wq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ftdi_fifo_phy.md
# ftdi_fifo_phy

Parametrised FT245-style parallel-FIFO physical layer that replaces the in-line FTDI handling of the debug bridge. It owns both directions through buffers: a send FIFO and a new receive FIFO. It adds configurable RD#/WR# strobe width and selectable arbitration. It also generates a SIWU flush after idle or on request, plus activity LEDs. It sits between the FTDI pads and the bridge protocol FSM.

## Interface
- CAddrLen, 8: log2 depth of each FIFO (send and receive both hold 2^CAddrLen bytes).
- CStrobeLen, 1: width of RD/WR strobe in enabled cycles, 1..15.
- CArbMode, 0: 0 = receive has priority; 1 = round-robin (direction alternates when both are ready).
- CFlushIdle, 4: enabled idle cycles after send activity before SIWU, 1..15.
- CLedLen, 12: LED stretch counter width, counted on ASync1M.
- AClkH  in  1  clock; single clock domain.
- AResetH  in  1  reset, asynchronous, active-high.
- AClkHEn  in  1  clock enable; no register changes when 0.
- ADbgDataI  in  8  pad data in.
- ADbgDataO  out  8  pad data out.
- ADbgDataOE  out  1  pad output enable.
- ADbgRF  in  1  FTDI has data to read (active-high).
- ADbgTE  in  1  FTDI can accept data (active-high).
- ADbgRd  out  1  read strobe (active-high).
- ADbgWr  out  1  write strobe (active-high).
- ADbgSiwu  out  1  send-immediate pulse.
- ADbgLed  out  2  [1] send LED, [0] receive LED.
- ASync1M  in  1  1 MHz tick for LED stretch.
- ASendData  in  8  user byte to send.
- ASendNow  in  1  push ASendData.
- ASendHasSpace  out  1  send FIFO not full.
- ARecvData  out  8  head of receive FIFO.
- ARecvRdEn  in  1  pop receive FIFO.
- ARecvHasData  out  1  receive FIFO not empty.
- AFlushReq  in  1  request immediate SIWU.
- ASendOvf  out  1  sticky: push while full.
- AClrErr  in  1  clear ASendOvf.

## Operation
- ADbgRF and ADbgTE are registered once (FRF, FTE) before use.
- FSM states: Idle, RdStb, RdCap, WrSetup, WrStb, Gap.
- Idle -> RdStb when FRF and the receive FIFO has space.
- Idle -> WrSetup when FTE and the send FIFO is non-empty.
- Both ready: CArbMode=0 picks RdStb. CArbMode=1 picks the direction not served last; the last-served flag resets to "send".
- RdStb: ADbgRd=1 for CStrobeLen cycles. ADbgDataI is latched on the last RdStb cycle.
- RdCap: ADbgRd=0; the latched byte is written to the receive FIFO; -> Gap.
- WrSetup: ADbgDataOE=1; ADbgDataO = send FIFO head; ADbgWr=0; lasts 1 cycle.
- WrStb: ADbgDataOE=1, ADbgWr=1 for CStrobeLen cycles. The send FIFO pops on the last WrStb cycle. -> Gap.
- Gap: all strobes and OE are 0 for 1 cycle; -> Idle. This guarantees bus turnaround.
- Send push while full: byte dropped, ASendOvf=1. AClrErr clears it; a simultaneous overflow wins.
- Simultaneous push and pop on each FIFO are allowed in any state.
- Flush: busy = send FIFO non-empty or state in {WrSetup, WrStb}. After busy has been seen, CFlushIdle consecutive non-busy enabled cycles produce a 1-cycle ADbgSiwu pulse; the count then re-arms on the next busy.
- AFlushReq while not busy pulses SIWU on the next cycle. While busy, the request is held and served by the idle rule.
- LEDs: RdStb entry restarts LED[0]; WrSetup entry restarts LED[1]. Each LED is lit while its counter is non-zero. Counters load all-ones and decrement on ASync1M.

## Timing
- Reset values: ADbgDataO=0, ADbgDataOE=0, ADbgRd=0, ADbgWr=0, ADbgSiwu=0, ADbgLed=0, ASendOvf=0, ARecvHasData=0, ARecvData=0, ASendHasSpace=1. FSM resets to Idle and FIFOs to empty.
- Reset asserted mid-transfer forces Idle immediately. Strobes and OE drop asynchronously and the partial byte is discarded.
- ADbgRF rising to ADbgRd rising: 2 enabled cycles (register, then Idle decision).
- Read transfer occupancy: CStrobeLen+2 cycles. Write transfer occupancy: CStrobeLen+2 cycles.
- ASendNow to ASendHasData-driven WrSetup: 2 enabled cycles with FTE=1.
- Receive FIFO write to ARecvHasData=1: 1 cycle; ARecvData is first-word-fall-through.
- All counters and FIFOs hold when AClkHEn=0.

## Test plan
- Push 0x12, 0x34 with TE=1, RF=0, CStrobeLen=2 -> per byte: WrSetup 1 cycle, Wr high 2 cycles with DataO 0x12 then 0x34, then SIWU pulses CFlushIdle cycles after the last WrStb.
- RF=1 with pad bytes 0xA5, 0x5A -> Rd pulses of CStrobeLen; ARecvData=0xA5, pops to 0x5A; OE stays 0 throughout.
- RF=1, TE=1, send FIFO non-empty, CArbMode=1 -> sequence Rd, Wr, Rd, Wr; CArbMode=0 -> reads until RF=0.
- Fill send FIFO to 2^CAddrLen with TE=0, then push 0xFF -> ASendHasSpace=0, ASendOvf=1, 0xFF never appears; AClrErr clears it.
- Receive FIFO full with RF=1 -> Rd stays 0; one ARecvRdEn -> exactly one new read.
- AResetH during WrStb -> Wr and OE go 0 at once, the FIFO is empty after release, and ASendHasSpace=1.
